// File: rtl/bus_move_sequencer_if.sv
// Signals between the register-move sequencer, its control unit and the shared
// tri-state register bus. The slave view belongs to the sequencer.
interface bus_move_sequencer_if #(
  parameter int NrOfBits = 8,
  parameter int NrOfRegs = 8,
  parameter int SelBits  = 3
);
  logic                req;
  logic [SelBits-1:0]  src_sel;
  logic [SelBits-1:0]  dst_sel;
  logic [NrOfBits-1:0] bus_in;
  logic [NrOfRegs-1:0] cs;
  logic [NrOfRegs-1:0] load_en;
  logic [NrOfBits-1:0] data_out;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output req, src_sel, dst_sel, bus_in,
    input  cs, load_en, data_out, busy, done, err
  );

  modport slave (
    input  req, src_sel, dst_sel, bus_in,
    output cs, load_en, data_out, busy, done, err
  );
endinterface

// File: rtl/bus_move_sequencer.sv
// Bus initiator: one register-to-register move per request (drive, sample, write, done).
// Every output is registered; Tick gates all updates except the synchronous Reset.
module bus_move_sequencer #(
  parameter int NrOfBits = 8,
  parameter int NrOfRegs = 8,
  parameter int SelBits  = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Tick,
  bus_move_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, WRITE, DONE} state_t;

  state_t              state, state_nxt;
  logic [SelBits-1:0]  src_q, dst_q, src_nxt, dst_nxt;
  logic                accept, reject, drive;

  logic [NrOfRegs-1:0] cs_q, cs_nxt, load_en_q, load_en_nxt;
  logic [NrOfBits-1:0] data_q, data_nxt;
  logic                busy_q, busy_nxt, done_q, done_nxt, err_q, err_nxt;

  // Reset wins over Tick so a move can be aborted even while stalled.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cs_q      <= '1;
      load_en_q <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (Tick) begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      state     <= state_nxt;
      src_q     <= src_nxt;
      dst_q     <= dst_nxt;
      cs_q      <= cs_nxt;
      load_en_q <= load_en_nxt;
      data_q    <= data_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin : next_state
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_nxt = state;
    src_nxt   = src_q;
    dst_nxt   = dst_q;
    accept    = 1'b0;
    reject    = (32'(bus.src_sel) >= NrOfRegs) || (32'(bus.dst_sel) >= NrOfRegs) ||
                (bus.src_sel == bus.dst_sel);
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          accept    = 1'b1;
          src_nxt   = bus.src_sel;
          dst_nxt   = bus.dst_sel;
          state_nxt = reject ? DONE : DRIVE;
        end
      end
      DRIVE:   state_nxt = SAMPLE;
      SAMPLE:  state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  always_comb begin : outputs
    drive       = (state_nxt == DRIVE) || (state_nxt == SAMPLE) || (state_nxt == WRITE);
    cs_nxt      = '1;
    load_en_nxt = '0;
    for (int i = 0; i < NrOfRegs; i++) begin
      cs_nxt[i]      = !(drive && (32'(src_nxt) == i));
      load_en_nxt[i] = (state_nxt == WRITE) && (32'(dst_nxt) == i);
    end
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    err_nxt  = accept ? reject : err_q;
    data_nxt = (state == SAMPLE) ? bus.bus_in : data_q;
  end

  assign bus.cs       = cs_q;
  assign bus.load_en  = load_en_q;
  assign bus.data_out = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule

// File: doc/bus_move_sequencer.md
Name: bus_move_sequencer

Overview:
- Initiator side of the CPU's shared tri-state register bus: performs one register-to-register move per request.
- Drives the per-register output-disable lines (cs; 1 = high-Z) and per-register load enables.
- Samples the bus and reports the transferred value.
- Sits between the control unit (req/ack) and the register file of tri-stated registers.

Parameters:
- NrOfBits, 8, bus/data width
- NrOfRegs, 8, number of registers on the bus (2..2^SelBits)
- SelBits, 3, width of source/destination select

Ports:
- Clock  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Tick  in  1  clock-enable; FSM advances only on edges where Tick=1
- req  in  1  move request, sampled in IDLE only
- src_sel  in  SelBits  source register index
- dst_sel  in  SelBits  destination register index
- bus_in  in  NrOfBits  resolved value of the shared bus
- cs  out  NrOfRegs  per-register output disable; 0 = register drives bus
- load_en  out  NrOfRegs  per-register load enable (one-hot or zero)
- data_out  out  NrOfBits  value captured from bus during the last move
- busy  out  1  high from accept until return to IDLE
- done  out  1  one-cycle pulse at move completion
- err  out  1  status of last move: 1 = rejected/aborted, valid with done

Behaviour:
- Reset (synchronous, evaluated regardless of Tick): state=IDLE; cs all 1; load_en 0; data_out 0; busy 0; done 0; err 0. Reset mid-move aborts immediately: cs released and load_en deasserted on the reset edge; no partial write.
- All outputs are registered. States: IDLE, DRIVE, SAMPLE, WRITE, DONE.
- IDLE:
  - On Tick & req: latch src_sel/dst_sel and set busy=1.
  - If src>=NrOfRegs, dst>=NrOfRegs, or src==dst: go to DONE with err=1; cs stays all 1.
  - Otherwise: go to DRIVE with err=0.
- DRIVE: cs[src]=0, all other cs bits 1 (bus settles). Next: SAMPLE.
- SAMPLE: cs[src] held 0; data_out <= bus_in. Next: WRITE.
- WRITE: cs[src] held 0; load_en[dst]=1 for exactly this state. Next: DONE.
- DONE: cs all 1; load_en 0; done=1 for one clock; busy=0 on exit. Next: IDLE.
- Tick=0 freezes state and all outputs (done/load_en stay asserted if already asserted; the destination register also gates on Tick, so no double load occurs).
- Latency with Tick held 1: req accepted at edge N -> DRIVE after N, SAMPLE after N+1, WRITE after N+2, DONE after N+3. done is high in cycle N+4; the earliest next accept is edge N+5. Rejected moves show done in cycle N+1.
- req while busy is ignored, not queued. req must be re-presented after done.
- Invariants:
  - At most one cs bit is 0 at any time.
  - load_en is never nonzero unless the cs bit of the latched source is 0.
  - cs and load_en are never both asserted on the same register index.
- err and data_out hold until the next accepted move. data_out is not updated on rejected moves.

Test Plan:
- Reset: assert Reset 2 cycles with req=1 -> cs=8'hFF, load_en=0, busy=0, done=0, data_out=0.
- Basic move: Tick=1, src=2, dst=5, bus_in=8'hA5 while cs[2]=0, req pulse -> cs=8'hFB for 3 cycles; load_en=8'h20 for 1 cycle (3rd); done pulse 4 cycles after accept; data_out=8'hA5; err=0.
- Rejection: src=3, dst=3 -> done one cycle after accept with err=1, cs stays 8'hFF, load_en never nonzero. Repeat with NrOfRegs=6, src=7 -> same response.
- Tick stall: Tick=0 for 3 cycles while in SAMPLE -> cs[src] held 0, no state advance, load_en=0; resume -> remaining sequence identical to basic move, total latency +3.
- Reset mid-move: assert Reset in WRITE (load_en=8'h20) -> next cycle cs=8'hFF, load_en=0, busy=0, no done pulse.
- Back-to-back: req held 1 continuously with src=1/dst=0, then src=0/dst=1 -> second move accepted only at edge after done; busy never overlaps; single-driver invariant holds throughout.
